aes128_enc_iter: RTL

- Iterative AES-128 encryption engine; one full cipher round per clock.
- Holds the 128-bit state and round-key registers, a round counter and the input/output handshakes.
- Per round it computes SubBytes, then ShiftRows, then the team's mixcolumn block (combinational, instantiated here), then AddRoundKey, and expands the next round key on the fly.
- Sits between the Wishbone-facing register file (upstream, supplies key/plaintext) and the result/readback logic (downstream).

---
 rtl/aes128_enc_iter.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/aes128_enc_iter.sv
`default_nettype none
// ============================================================================
// Module      : aes128_enc_iter (with aes128_enc_iter_sbox, aes128_enc_iter_mixcol)
// Description : Iterative AES-128 encryption, one cipher round per clock.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// S-box: GF(2^8) inverse (poly 0x11B) followed by the 0x63 affine transform
// ----------------------------------------------------------------------------
module aes128_enc_iter_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_s
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] w_x;
    logic [7:0] w_inv;

    // a^254 = a^2 * a^4 * ... * a^128 gives the inverse, and maps 0 to 0
    always_comb begin
        w_x   = i_a;
        w_inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            w_x   = gf_mul(w_x, w_x);
            w_inv = gf_mul(w_inv, w_x);
        end
    end

    assign o_s = w_inv
               ^ {w_inv[6:0], w_inv[7]}
               ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]}
               ^ {w_inv[3:0], w_inv[7:4]}
               ^ 8'h63;

endmodule

// ----------------------------------------------------------------------------
// MixColumns on one column; row 0 in [31:24]
// ----------------------------------------------------------------------------
module aes128_enc_iter_mixcol (
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] w_a0, w_a1, w_a2, w_a3;

    assign w_a0 = i_col[31:24];
    assign w_a1 = i_col[23:16];
    assign w_a2 = i_col[15:8];
    assign w_a3 = i_col[7:0];

    assign o_col[31:24] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign o_col[23:16] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
    assign o_col[15:8]  = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
    assign o_col[7:0]   = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);

endmodule

// ----------------------------------------------------------------------------
// Top: state/round-key registers, round counter and handshakes
// ----------------------------------------------------------------------------
module aes128_enc_iter #(
    parameter int unsigned ZEROIZE = 1
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] key_i,
    input  logic [127:0] pt_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] ct_o,
    output logic         busy_o,
    output logic [3:0]   round_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] c_LAST_ROUND = 4'd10;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    logic [1:0]   r_state;
    logic [127:0] r_st;
    logic [127:0] r_rk;
    logic [3:0]   r_rnd;

    // ---------------- on-the-fly key expansion ----------------
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot, w_sub, w_t;
    logic [31:0]  w_k0, w_k1, w_k2, w_k3;
    logic [127:0] w_rk_next;

    assign w_w0  = r_rk[127:96];
    assign w_w1  = r_rk[95:64];
    assign w_w2  = r_rk[63:32];
    assign w_w3  = r_rk[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    generate
        for (genvar i = 0; i < 4; i++) begin : g_ksb
            aes128_enc_iter_sbox u_sbox (
                .i_a (w_rot[31-8*i -: 8]),
                .o_s (w_sub[31-8*i -: 8])
            );
        end
    endgenerate

    assign w_t       = w_sub ^ {rcon(r_rnd), 24'h000000};
    assign w_k0      = w_w0 ^ w_t;
    assign w_k1      = w_w1 ^ w_k0;
    assign w_k2      = w_w2 ^ w_k1;
    assign w_k3      = w_w3 ^ w_k2;
    assign w_rk_next = {w_k0, w_k1, w_k2, w_k3};

    // ---------------- round datapath ----------------
    logic [127:0] w_sb, w_sr, w_mc, w_next;

    generate
        for (genvar k = 0; k < 16; k++) begin : g_sb
            aes128_enc_iter_sbox u_sbox (
                .i_a (r_st[127-8*k -: 8]),
                .o_s (w_sb[127-8*k -: 8])
            );
        end

        // Byte (row r, column c) takes the byte of row r from column c+r
        for (genvar c = 0; c < 4; c++) begin : g_sr_col
            for (genvar r = 0; r < 4; r++) begin : g_sr_row
                assign w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end

        for (genvar c = 0; c < 4; c++) begin : g_mc
            aes128_enc_iter_mixcol u_mixcol (
                .i_col (w_sr[127-32*c -: 32]),
                .o_col (w_mc[127-32*c -: 32])
            );
        end
    endgenerate

    assign w_next = ((r_rnd == c_LAST_ROUND) ? w_sr : w_mc) ^ w_rk_next;

    // ---------------- control ----------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_st        <= '0;
            r_rk        <= '0;
            r_rnd       <= 4'd0;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            round_o     <= 4'd0;
            ct_o        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_st       <= pt_i ^ key_i;
                        r_rk       <= key_i;
                        r_rnd      <= 4'd1;
                        round_o    <= 4'd1;
                        busy_o     <= 1'b1;
                        in_ready_o <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_st <= w_next;
                    r_rk <= w_rk_next;
                    if (r_rnd == c_LAST_ROUND) begin
                        ct_o        <= w_next;
                        out_valid_o <= 1'b1;
                        busy_o      <= 1'b0;
                        r_rnd       <= 4'd0;
                        round_o     <= 4'd0;
                        r_state     <= S_DONE;
                    end else begin
                        r_rnd   <= r_rnd + 4'd1;
                        round_o <= r_rnd + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        r_state     <= S_IDLE;
                        if (ZEROIZE != 0) begin
                            r_st <= '0;
                            r_rk <= '0;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    in_ready_o  <= 1'b1;
                    out_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    round_o     <= 4'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
